instr_encoder: RTL and testbench

//  Field-level ARM instruction encoder and loader: the inverse of the pipeline's decode stage.

---
 rtl/instr_encoder.sv | 109 ++++++++++
 tb/tb_instr_encoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Field-level instruction encoder: packs one request per handshake into a 32-bit word,
// queues it in a fall-through FIFO and streams the words as sequential memory writes.
module instr_encoder #(
  parameter int              DEPTH     = 4,
  parameter int              AW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_kind,
  input  logic [3:0]    cond,
  input  logic [3:0]    opcode,
  input  logic          s_bit,
  input  logic [3:0]    pubw,
  input  logic [3:0]    rn,
  input  logic [3:0]    rd,
  input  logic [3:0]    rm,
  input  logic [3:0]    rs,
  input  logic [23:0]   imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  output logic [15:0]   count,
  output logic          err
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0] fifoMem [DEPTH];
  logic [PW:0] wrPtr;
  logic [PW:0] rdPtr;
  logic [31:0] encWord;
  logic        isLegal;
  logic        fifoFull;
  logic        fifoEmpty;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    encWord = '0;
    isLegal = 1'b1;
    case (req_kind)
      3'd0: encWord = {cond, 2'b00, 1'b0, opcode, s_bit, rn, rd, imm[11:0]};
      3'd1: encWord = {cond, 2'b00, 1'b1, opcode, s_bit, rn, rd, imm[11:0]};
      3'd2: begin
        encWord = {cond, 2'b01, 1'b0, pubw, s_bit, rn, rd, imm[11:0]};
        // Pre-indexed writeback into the PC is rejected.
        isLegal = !((rd == 4'hF) && pubw[3] && pubw[0]);
      end
      3'd3: encWord = {cond, 3'b101, s_bit, imm[23:0]};
      3'd4: begin
        encWord = {cond, 4'b0000, opcode[2:0], s_bit, rd, rn, rs, 4'b1001, rm};
        isLegal = !opcode[3] && (opcode[2:0] inside {3'b000, 3'b001, 3'b100, 3'b110});
      end
      3'd5: encWord = {cond, 8'b01110001, rd, 4'hF, rs, 4'b0001, rm};
      default: isLegal = 1'b0;
    endcase
  end

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign mem_we    = !fifoEmpty;
  assign mem_wdata = fifoMem[rdPtr[PW-1:0]];
  assign pop       = mem_we && mem_ready;
  assign req_ready = !fifoFull || pop;
  assign accept    = req_valid && req_ready;
  assign push      = accept && isLegal;

  // When full, the slot being written is the one popped this same edge.
  always_ff @(posedge clk) begin
    if (push && !start) begin
      fifoMem[wrPtr[PW-1:0]] <= encWord;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      mem_addr <= BASE_ADDR;
      count    <= '0;
      err      <= 1'b0;
    end else if (start) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      mem_addr <= BASE_ADDR;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + {{PW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rdPtr    <= rdPtr + {{PW{1'b0}}, 1'b1};
        mem_addr <= mem_addr + AW'(4);
        count    <= count + 16'd1;
      end
      if (accept && !isLegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [3:0]  pubw;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [3:0]  rm;
  logic [3:0]  rs;
  logic [23:0] imm;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] count;
  logic        err;

  instr_encoder #(.DEPTH(DEPTH), .AW(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .cond(cond), .opcode(opcode), .s_bit(s_bit), .pubw(pubw),
    .rn(rn), .rd(rd), .rm(rm), .rs(rs), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          tests = 0;
  int          fails = 0;
  int unsigned expQ[$];
  logic [31:0] expAddr = 32'h0;
  logic [15:0] expCount = 16'h0;
  logic        expErr = 1'b0;
  logic        dutAcc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoding built as a sum of shifted fields.
  function automatic logic [31:0] refEnc();
    logic [31:0] c;
    logic [31:0] w;
    c = 32'(cond) << 28;
    case (req_kind)
      3'd0, 3'd1: w = c | (32'(req_kind) << 25) | (32'(opcode) << 21) | (32'(s_bit) << 20)
                      | (32'(rn) << 16) | (32'(rd) << 12) | (32'(imm) & 32'hFFF);
      3'd2: w = c | (32'd1 << 26) | (32'(pubw) << 21) | (32'(s_bit) << 20)
                | (32'(rn) << 16) | (32'(rd) << 12) | (32'(imm) & 32'hFFF);
      3'd3: w = c | (32'd5 << 25) | (32'(s_bit) << 24) | 32'(imm);
      3'd4: w = c | ((32'(opcode) % 8) << 21) | (32'(s_bit) << 20) | (32'(rd) << 16)
                | (32'(rn) << 12) | (32'(rs) << 8) | (32'd9 << 4) | 32'(rm);
      default: w = c | (32'h71 << 20) | (32'(rd) << 16) | (32'hF << 12)
                   | (32'(rs) << 8) | (32'd1 << 4) | 32'(rm);
    endcase
    return w;
  endfunction

  function automatic bit refLegal();
    if (req_kind > 3'd5) return 1'b0;
    if (req_kind == 3'd4) return (opcode == 4'd0 || opcode == 4'd1 || opcode == 4'd4 || opcode == 4'd6);
    if (req_kind == 3'd2) return !(rd == 4'd15 && pubw[3] && pubw[0]);
    return 1'b1;
  endfunction

  function automatic bit expReady();
    return (expQ.size() < DEPTH) || (expQ.size() > 0 && mem_ready);
  endfunction

  task automatic modelClear();
    expQ.delete();
    expAddr  = 32'h0;
    expCount = 16'h0;
    expErr   = 1'b0;
  endtask

  task automatic checkOutputs();
    chk("req_ready", 32'(req_ready), 32'(expReady()));
    chk("mem_we", 32'(mem_we), 32'(expQ.size() > 0));
    if (expQ.size() > 0) chk("mem_wdata", mem_wdata, expQ[0]);
    chk("mem_addr", mem_addr, expAddr);
    chk("count", 32'(count), 32'(expCount));
    chk("err", 32'(err), 32'(expErr));
  endtask

  // Entered and left 1 time unit after a rising edge; inputs are already driven.
  task automatic cycle();
    bit accM;
    bit popM;
    #1;
    checkOutputs();
    accM   = req_valid && expReady();
    popM   = expQ.size() > 0 && mem_ready;
    dutAcc = req_valid && req_ready;
    @(posedge clk);
    if (start) begin
      modelClear();
    end else begin
      if (popM) begin
        void'(expQ.pop_front());
        expAddr  = expAddr + 32'd4;
        expCount = expCount + 16'd1;
      end
      if (accM) begin
        if (refLegal()) expQ.push_back(refEnc());
        else expErr = 1'b1;
      end
    end
    #1;
  endtask

  task automatic setReq(input logic [2:0] k, input logic [3:0] c, input logic [3:0] op,
                        input logic s, input logic [3:0] p, input logic [3:0] n,
                        input logic [3:0] d, input logic [3:0] m, input logic [3:0] t,
                        input logic [23:0] im);
    req_kind = k; cond = c; opcode = op; s_bit = s; pubw = p;
    rn = n; rd = d; rm = m; rs = t; imm = im;
    req_valid = 1'b1;
  endtask

  task automatic setMem(input int i);
    setReq(3'd2, 4'hE, 4'h0, 1'b1, 4'b1100, 4'(i + 1), 4'(i), 4'h0, 4'h0, 24'(i * 16 + 4));
  endtask

  task automatic drain();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 40 && expQ.size() > 0; c++) cycle();
    chk("drained_we", 32'(mem_we), 32'd0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0;
    setReq(3'd0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutputs();
    reset = 1'b1;
    cycle();
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_addr", mem_addr, 32'h0);

    // DP_IMM example word.
    mem_ready = 1'b1;
    setReq(3'd1, 4'hE, 4'b0100, 1'b1, 4'h0, 4'd1, 4'd2, 4'h0, 4'h0, 24'h0000FF);
    cycle();
    req_valid = 1'b0;
    #1;
    chk("dpimm_word", mem_wdata, 32'hE29120FF);
    chk("dpimm_addr", mem_addr, 32'h0);
    drain();

    // Six MEM requests against a stalled memory.
    pulseStart();
    mem_ready = 1'b0;
    i = 0;
    for (int c = 0; c < 6; c++) begin
      setMem(i);
      cycle();
      if (dutAcc) i++;
    end
    chk("mem_accepts_stalled", 32'(i), 32'd4);
    mem_ready = 1'b1;
    for (int c = 0; c < 20 && i < 6; c++) begin
      setMem(i);
      cycle();
      if (dutAcc) i++;
    end
    chk("mem_accepts_total", 32'(i), 32'd6);
    drain();
    chk("mem_count", 32'(count), 32'd6);
    chk("mem_last_addr", mem_addr, 32'h18);

    // MUL, DIV and branch-with-link queued, then streamed.
    mem_ready = 1'b0;
    setReq(3'd4, 4'hE, 4'b0001, 1'b0, 4'h0, 4'd4, 4'd3, 4'd6, 4'd5, 24'h0);
    cycle();
    setReq(3'd5, 4'hE, 4'h0, 1'b0, 4'h0, 4'h0, 4'd7, 4'd1, 4'd2, 24'h0);
    cycle();
    setReq(3'd3, 4'hE, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 24'hFFFFFE);
    cycle();
    req_valid = 1'b0;
    #1;
    chk("mul_word", mem_wdata, 32'hE0234596);
    mem_ready = 1'b1;
    cycle();
    cycle();
    chk("bl_word", mem_wdata, 32'hEBFFFFFE);
    drain();

    // Illegal request is accepted but dropped; err is sticky.
    pulseStart();
    setReq(3'd7, 4'hE, 4'h0, 1'b0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 24'h5);
    cycle();
    setReq(3'd0, 4'h0, 4'b1101, 1'b0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 24'h012);
    cycle();
    drain();
    repeat (2) cycle();
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_count", 32'(count), 32'd1);

    // start while words are queued drops everything, including a same-cycle accept.
    mem_ready = 1'b0;
    setReq(3'd6, 4'hE, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0);
    cycle();
    for (int c = 0; c < 3; c++) begin
      setMem(c);
      cycle();
    end
    start = 1'b1;
    mem_ready = 1'b1;
    setMem(9);
    cycle();
    start = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("start_we", 32'(mem_we), 32'd0);
    chk("start_addr", mem_addr, 32'h0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_count", 32'(count), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      setReq(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom),
             4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             24'($urandom));
      if ($urandom_range(0, 3) == 0) rd = 4'hF;
      req_valid = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      start     = ($urandom_range(0, 59) == 0);
      cycle();
    end
    start = 1'b0;
    drain();

    // Asynchronous reset mid-stream.
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      setMem(c);
      cycle();
    end
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    modelClear();
    #1;
    chk("areset_we", 32'(mem_we), 32'd0);
    chk("areset_addr", mem_addr, 32'h0);
    chk("areset_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
